add_seq: RTL

- Multi-cycle wide adder/subtractor sequencer.
- Accepts a W-bit operand pair plus an op select over a valid/ready handshake.
- Processes the operands one SW-bit slice per cycle, least-significant slice first, through a single shared carry-look-ahead slice.
- Carries between cycles in a registered carry flop, then returns the full sum with carry-out and signed-overflow flags.
- Sits between operand producers and consumers where a full W-bit CLA is too large or too slow for the clock.

---
 rtl/add_seq_pkg.sv | 28 ++
 rtl/add_seq_chk.sv | 35 +++
 rtl/add_seq_cla_slice.sv | 68 ++++++
 rtl/add_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the multi-cycle adder/subtractor sequencer:
//   - state_e      : sequencer state encoding (IDLE, CALC, DONE)
//   - OP_ADD/OP_SUB: encoding of the sub_i operation select
//   - cnt_width()  : width of the slice counter for a given slice count
// -----------------------------------------------------------------------------
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Slice counter width; a single-slice configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned ns);
    if (ns <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(ns);
    end
  endfunction

endpackage

// File: rtl/add_seq_chk.sv
// -----------------------------------------------------------------------------
// add_seq_chk
// Simulation-only property checker for add_seq.
//   - Rejects illegal W/SW combinations at elaboration.
//   - Result outputs must not move while a result is offered and not taken.
// Ports: clock, reset and the result-side outputs of add_seq (all inputs).
// -----------------------------------------------------------------------------
module add_seq_chk #(
  parameter int unsigned W  = 64,
  parameter int unsigned SW = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  input logic         valid_o,
  input logic         ready_i,
  input logic [W-1:0] s_o,
  input logic         co_o,
  input logic         ovf_o
);

  generate
    if (((W % SW) != 32'd0) || ((SW % 32'd4) != 32'd0) || ((W / SW) < 32'd2)) begin : g_bad_cfg
      $fatal(1, "add_seq: W must be a multiple of SW, SW a multiple of 4, W/SW >= 2");
    end
  endgenerate

  property p_hold_result;
    @(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i) |=> (valid_o && $stable(s_o) && $stable(co_o) && $stable(ovf_o));
  endproperty

  a_hold_result: assert property (p_hold_result)
    else $error("add_seq: result changed while stalled");

endmodule

// File: rtl/add_seq_cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Combinational SW-bit carry-look-ahead adder. Built from 4-bit lookahead
// groups; the group carries ripple from one group to the next.
// Ports:
//   i_a, i_b  : SW-bit addends
//   i_c       : carry in
//   o_s       : SW-bit sum
//   o_c       : carry out of the MSB
//   o_c_msb   : carry into the MSB (used for signed-overflow detection)
// -----------------------------------------------------------------------------
module cla_slice #(
  parameter int unsigned SW = 16
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_c,
  output logic [SW-1:0] o_s,
  output logic          o_c,
  output logic          o_c_msb
);

  localparam int unsigned NG = SW / 4;

  logic [SW-1:0] w_g;   // bit generate
  logic [SW-1:0] w_p;   // bit propagate
  logic [SW-1:0] w_c;   // carry into each bit
  logic [NG:0]   w_gc;  // carry into each 4-bit group

  assign w_g     = i_a & i_b;
  assign w_p     = i_a ^ i_b;
  assign w_gc[0] = i_c;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] w_gg;
      logic [3:0] w_gp;
      logic       w_cin;

      assign w_gg  = w_g[4*gi +: 4];
      assign w_gp  = w_p[4*gi +: 4];
      assign w_cin = w_gc[gi];

      // Every carry inside the group is a flat function of the group carry-in.
      assign w_c[4*gi + 0] = w_cin;
      assign w_c[4*gi + 1] = w_gg[0]
                           | (w_gp[0] & w_cin);
      assign w_c[4*gi + 2] = w_gg[1]
                           | (w_gp[1] & w_gg[0])
                           | (w_gp[1] & w_gp[0] & w_cin);
      assign w_c[4*gi + 3] = w_gg[2]
                           | (w_gp[2] & w_gg[1])
                           | (w_gp[2] & w_gp[1] & w_gg[0])
                           | (w_gp[2] & w_gp[1] & w_gp[0] & w_cin);
      assign w_gc[gi + 1]  = w_gg[3]
                           | (w_gp[3] & w_gg[2])
                           | (w_gp[3] & w_gp[2] & w_gg[1])
                           | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                           | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_cin);
    end
  endgenerate

  assign o_s     = w_p ^ w_c;
  assign o_c     = w_gc[NG];
  assign o_c_msb = w_c[SW-1];

endmodule

// File: rtl/add_seq.sv
// -----------------------------------------------------------------------------
// add_seq
// Multi-cycle W-bit adder/subtractor. Operands are accepted over a
// valid/ready handshake, then summed one SW-bit slice per cycle (LS slice
// first) through a single shared cla_slice; the inter-slice carry lives in a
// register. The result is offered with carry-out and signed overflow.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   valid_i, ready_o   : operand handshake
//   sub_i, a_i, b_i    : operation select (0 add, 1 subtract) and operands
//   valid_o, ready_i   : result handshake
//   s_o, co_o, ovf_o   : sum/difference, carry-out (1 = no borrow), overflow
// -----------------------------------------------------------------------------
module add_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned W  = 64,
  parameter int unsigned SW = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         sub_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         ovf_o
);

  localparam int unsigned NS = W / SW;
  localparam int unsigned CW = cnt_width(NS);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_s;
  logic          r_co;
  logic          r_ovf;
  logic          r_ready;
  logic          r_valid;

  logic [31:0]   w_ofs;
  logic [SW-1:0] w_a_sl;
  logic [SW-1:0] w_b_sl;
  logic [SW-1:0] w_sum;
  logic          w_c_out;
  logic          w_c_msb;
  logic          w_last;

  // Bit offset of the slice currently being processed.
  assign w_ofs  = 32'(r_cnt) * SW;
  assign w_a_sl = r_a[w_ofs +: SW];
  assign w_b_sl = r_b[w_ofs +: SW];
  assign w_last = (r_cnt == CW'(NS - 32'd1));

  cla_slice #(
    .SW (SW)
  ) u_cla_slice (
    .i_a     (w_a_sl),
    .i_b     (w_b_sl),
    .i_c     (r_carry),
    .o_s     (w_sum),
    .o_c     (w_c_out),
    .o_c_msb (w_c_msb)
  );

  // Sequencer: operand capture, slice-by-slice accumulation, result hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i && r_ready) begin
            r_a     <= a_i;
            // Subtraction is a + ~b + 1: B is stored inverted and the +1
            // enters as the initial carry.
            r_b     <= (sub_i == OP_SUB) ? ~b_i : b_i;
            r_carry <= sub_i;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_s[w_ofs +: SW] <= w_sum;
          r_carry          <= w_c_out;
          if (w_last) begin
            r_co    <= w_c_out;
            // Overflow: carry into the word MSB differs from carry out of it.
            r_ovf   <= w_c_msb ^ w_c_out;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign s_o     = r_s;
  assign co_o    = r_co;
  assign ovf_o   = r_ovf;

  add_seq_chk #(
    .W  (W),
    .SW (SW)
  ) u_add_seq_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_o (r_valid),
    .ready_i (ready_i),
    .s_o     (r_s),
    .co_o    (r_co),
    .ovf_o   (r_ovf)
  );

endmodule
